// File: rtl/ropuf_pkg.sv
// Shared constants for the RO-PUF measurement blocks: state encoding,
// width helpers and the default oscillator counter width.
package ropuf_pkg;

   localparam int CNT_W_DEF = 16;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CLEAR   = 3'd1;
   localparam state_t ST_RUN     = 3'd2;
   localparam state_t ST_SETTLE  = 3'd3;
   localparam state_t ST_COMPARE = 3'd4;
   localparam state_t ST_DONE    = 3'd5;

   function automatic int timer_w(input int window);
      return $clog2(window + 1);
   endfunction

   function automatic int sel_w(input int n_pairs);
      return (n_pairs > 1) ? $clog2(2 * n_pairs) : 1;
   endfunction

endpackage

// File: rtl/ro_sat_counter.sv
// Saturating up-counter clocked directly by one ring oscillator.
// Holds at all-ones; cleared asynchronously by clr_i.
module ro_sat_counter
   import ropuf_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             ro_clk_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge ro_clk_i or posedge clr_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ropuf_pair_counter.sv
// Measures 2*N_PAIRS oscillators over a clk-timed window and compares pairs.
// start->done takes 2+WINDOW+SETTLE+2 cycles; start is ignored while busy.
module ropuf_pair_counter
   import ropuf_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int N_PAIRS = 8,
   parameter int WINDOW  = 1024,
   parameter int SETTLE  = 8
) (
   input  logic                      clk,
   input  logic                      Reset,
   input  logic                      start,
   input  logic [2*N_PAIRS-1:0]      ro_clk,
   output logic                      ro_en,
   output logic                      busy,
   output logic                      done,
   output logic                      resp_valid,
   output logic [N_PAIRS-1:0]        response,
   output logic [N_PAIRS-1:0]        unrel,
   input  logic [sel_w(N_PAIRS)-1:0] cnt_sel,
   output logic [CNT_W-1:0]          cnt_rdata
);

   localparam int N_RO  = 2 * N_PAIRS;
   localparam int RUN_W = timer_w(WINDOW);
   localparam int SET_W = timer_w(SETTLE);
   localparam int TMR_W = (RUN_W > SET_W) ? RUN_W : SET_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t                      state_q, state_d;
   logic [TMR_W-1:0]            timer_q, timer_d;
   logic                        ro_en_q, ro_en_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        resp_valid_q, resp_valid_d;
   logic                        cnt_clr_q, cnt_clr_d;
   logic [N_PAIRS-1:0]          response_q, unrel_q;
   logic [N_PAIRS-1:0]          cmp_resp, cmp_unrel;
   logic [N_RO-1:0][CNT_W-1:0]  cnt_live;
   logic [N_RO-1:0][CNT_W-1:0]  cnt_lat_q;
   logic                        ro_clr;

   // cnt_clr_q comes straight from a flop so the async clear cannot glitch
   assign ro_clr = Reset | cnt_clr_q;

   for (genvar g = 0; g < N_RO; g++) begin : g_ro
      (* DONT_TOUCH = "TRUE" *)
      ro_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .ro_clk_i (ro_clk[g]),
         .clr_i    (ro_clr),
         .cnt_o    (cnt_live[g])
      );
   end

   // Live counts are only sampled in COMPARE, after the oscillators have settled
   always_comb begin
      cmp_resp  = '0;
      cmp_unrel = '0;
      for (int p = 0; p < N_PAIRS; p++) begin
         cmp_resp[p]  = cnt_live[2*p] > cnt_live[2*p+1];
         cmp_unrel[p] = (cnt_live[2*p] == CNT_MAX) || (cnt_live[2*p+1] == CNT_MAX) ||
                        (cnt_live[2*p] == cnt_live[2*p+1]);
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CLEAR;
               timer_d = TMR_W'(1);
            end
         end
         ST_CLEAR: begin
            if (timer_q == '0) begin
               state_d = ST_RUN;
               timer_d = TMR_W'(WINDOW - 1);
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_RUN: begin
            if (timer_q == '0) begin
               state_d = ST_SETTLE;
               timer_d = TMR_W'(SETTLE - 1);
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_SETTLE: begin
            if (timer_q == '0) begin
               state_d = ST_COMPARE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_COMPARE: state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ro_en_d      = (state_d == ST_RUN);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      cnt_clr_d    = (state_d == ST_CLEAR);
      resp_valid_d = resp_valid_q;
      if (state_d == ST_DONE) begin
         resp_valid_d = 1'b1;
      end else if (state_q == ST_IDLE && start) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         ro_en_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         cnt_clr_q    <= 1'b0;
         response_q   <= '0;
         unrel_q      <= '0;
         cnt_lat_q    <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         ro_en_q      <= ro_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         resp_valid_q <= resp_valid_d;
         cnt_clr_q    <= cnt_clr_d;
         if (state_q == ST_COMPARE) begin
            cnt_lat_q  <= cnt_live;
            response_q <= cmp_resp;
            unrel_q    <= cmp_unrel;
         end
      end
   end

   always_comb begin
      cnt_rdata = '0;
      if (int'(cnt_sel) < N_RO) begin
         cnt_rdata = cnt_lat_q[cnt_sel];
      end
   end

   assign ro_en      = ro_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign resp_valid = resp_valid_q;
   assign response   = response_q;
   assign unrel      = unrel_q;

endmodule
